// File: rtl/pe_incha_scheduler_if.sv
// Requester/PE/response bundle for pe_incha_scheduler.
// slave = scheduler side, master = window producers, PE and result sink.
interface pe_incha_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 144,
  parameter int OUT_WIDTH  = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         pe_i_data;
  logic                          pe_i_valid;
  logic                          pe_ready;
  logic                          pe_ack;
  logic [OUT_WIDTH-1:0]          pe_o_data;
  logic                          pe_o_valid;
  logic [OUT_WIDTH-1:0]          rsp_data;
  logic                          rsp_valid;
  logic [IDW-1:0]                rsp_id;
  logic                          err_orphan;

  modport slave (
    input  req_data, req_valid, pe_ready, pe_ack, pe_o_data, pe_o_valid,
    output req_ready, pe_i_data, pe_i_valid, rsp_data, rsp_valid, rsp_id, err_orphan
  );

  modport master (
    output req_data, req_valid, pe_ready, pe_ack, pe_o_data, pe_o_valid,
    input  req_ready, pe_i_data, pe_i_valid, rsp_data, rsp_valid, rsp_id, err_orphan
  );
endinterface

// File: rtl/pe_incha_scheduler.sv
// Round-robin sharing of one PE between NUM_REQ window producers, with a tag FIFO
// returning each result's requester ID. Optional counters under PE_SCHED_STATS_EN.
module pe_incha_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 144,
  parameter int OUT_WIDTH  = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pe_incha_scheduler_if.slave   bus
`ifdef PE_SCHED_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0] stat_grants,
  output logic [31:0]           stat_stall
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  rr_ptr, grant, pick;
  logic           found;
  logic [IW-1:0]  tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  tag_count;
  logic           push, pop, tag_empty, tag_full;
  logic           unused_pe_ready;

  // pe_ack alone marks capture; pe_ready is informational here
  assign unused_pe_ready = bus.pe_ready;

  assign tag_empty = (tag_count == '0);
  assign tag_full  = (tag_count == CW'(TAG_DEPTH));
  assign pop       = bus.pe_o_valid && !tag_empty;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.pe_i_valid = 1'b0;
    bus.pe_i_data  = '0;
    bus.req_ready  = '0;
    push           = 1'b0;
    case (state)
      IDLE: if (found && !tag_full) state_nxt = GRANT;
      GRANT: begin
        bus.pe_i_valid = 1'b1;
        bus.pe_i_data  = bus.req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        if (bus.pe_ack) begin
          bus.req_ready[grant] = 1'b1;
          push                 = 1'b1;
          state_nxt            = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      grant          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tag_count      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_id     <= '0;
      bus.err_orphan <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == GRANT) grant <= pick;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      tag_count <= tag_count + 1'b1;
      else if (pop && !push) tag_count <= tag_count - 1'b1;
      bus.rsp_valid <= bus.pe_o_valid;
      if (bus.pe_o_valid) begin
        bus.rsp_data <= bus.pe_o_data;
        bus.rsp_id   <= tag_empty ? '0 : tag_mem[rd_ptr];
        if (tag_empty) bus.err_orphan <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

`ifdef PE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++)
        if (bus.req_ready[r]) stat_grants[r*32 +: 32] <= stat_grants[r*32 +: 32] + 32'd1;
      if (bus.pe_i_valid && !bus.pe_ack && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pe_incha_scheduler.sv
// Directed bench for pe_incha_scheduler: arbitration order, tag FIFO full/simultaneous
// push-pop, orphan results and mid-operation reset.
module tb_pe_incha_scheduler;
  localparam int NR = 4;
  localparam int DW = 144;
  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_incha_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus();

`ifdef PE_SCHED_STATS_EN
  logic [32*NR-1:0] stat_grants;
  logic [31:0]      stat_stall;
`endif

  pe_incha_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .TAG_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PE_SCHED_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  function automatic logic [DW-1:0] slice_val(input int r);
    logic [15:0] w;
    w = 16'hC0D0 + 16'(r);
    return {9{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    for (int i = 0; i < 20 && !bus.pe_i_valid; i++) tick();
    ok = bus.pe_i_valid;
  endtask

  task automatic test_reset();
    bus.req_valid  = 4'b1111;
    bus.pe_ready   = 1'b1;
    bus.pe_ack     = 1'b0;
    bus.pe_o_valid = 1'b0;
    bus.pe_o_data  = '0;
    for (int r = 0; r < NR; r++) bus.req_data[r*DW +: DW] = slice_val(r);
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.pe_i_valid !== 1'b0) begin errors++; $display("FAIL reset_pe_i_valid: got %b want 0", bus.pe_i_valid); end
    checks++; if (bus.pe_i_data !== '0) begin errors++; $display("FAIL reset_pe_i_data: got %h want 0", bus.pe_i_data); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    checks++; if (bus.err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b want 0", bus.err_orphan); end
    rst_n = 1'b1;
  endtask

  // All requesters valid, ack one cycle after pe_i_valid, result returned after each
  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    bit ok;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_grant_timeout[%0d]: pe_i_valid got 0 want 1", i); end
      checks++; if (bus.pe_i_data !== slice_val(order[i])) begin errors++; $display("FAIL rr_pe_i_data[%0d]: got %h want %h", i, bus.pe_i_data, slice_val(order[i])); end
      tick();
      bus.pe_ack = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'(1 << order[i])) begin errors++; $display("FAIL rr_req_ready[%0d]: got %b want %b", i, bus.req_ready, 4'(1 << order[i])); end
      tick();
      bus.pe_ack = 1'b0;
      if (i == 4) bus.req_valid = 4'b0000;
      bus.pe_o_valid = 1'b1;
      bus.pe_o_data  = 32'h1000 + 32'(i);
      tick();
      bus.pe_o_valid = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 2'(order[i])) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %0d want %0d", i, bus.rsp_id, order[i]); end
      checks++; if (bus.rsp_data !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL rr_rsp_data[%0d]: got %h want %h", i, bus.rsp_data, 32'h1000 + 32'(i)); end
    end
  endtask

  // Only requester 2 valid: picked from rr_ptr=1, then again from rr_ptr=3
  task automatic test_single_requester();
    bit ok;
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_grant_timeout[%0d]: pe_i_valid got 0 want 1", i); end
      checks++; if (bus.pe_i_data !== slice_val(2)) begin errors++; $display("FAIL single_pe_i_data[%0d]: got %h want %h", i, bus.pe_i_data, slice_val(2)); end
      tick();
      bus.pe_ack = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready[%0d]: got %b want 0100", i, bus.req_ready); end
      tick();
      bus.pe_ack = 1'b0;
      if (i == 1) bus.req_valid = 4'b0000;
      bus.pe_o_valid = 1'b1;
      bus.pe_o_data  = 32'h2000 + 32'(i);
      tick();
      bus.pe_o_valid = 1'b0;
      checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id[%0d]: got %0d want 2", i, bus.rsp_id); end
    end
  endtask

  // Four acks without results fill the tag FIFO; one result reopens arbitration
  task automatic test_fifo_full();
    int order[4] = '{3, 0, 1, 2};
    bit ok;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_grant_timeout[%0d]: pe_i_valid got 0 want 1", i); end
      tick();
      bus.pe_ack = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'(1 << order[i])) begin errors++; $display("FAIL full_req_ready[%0d]: got %b want %b", i, bus.req_ready, 4'(1 << order[i])); end
      tick();
      bus.pe_ack = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      checks++; if (bus.pe_i_valid !== 1'b0) begin errors++; $display("FAIL full_blocked[%0d]: pe_i_valid got %b want 0", j, bus.pe_i_valid); end
      tick();
    end
    bus.pe_o_valid = 1'b1;
    bus.pe_o_data  = 32'h3000;
    tick();
    bus.pe_o_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3) begin errors++; $display("FAIL full_first_rsp: got valid=%b id=%0d want valid=1 id=3", bus.rsp_valid, bus.rsp_id); end
    checks++; if (bus.pe_i_valid !== 1'b0) begin errors++; $display("FAIL full_pop_cycle: pe_i_valid got %b want 0", bus.pe_i_valid); end
    tick();
    checks++; if (bus.pe_i_valid !== 1'b1) begin errors++; $display("FAIL full_regrant: pe_i_valid got %b want 1", bus.pe_i_valid); end
    checks++; if (bus.pe_i_data !== slice_val(3)) begin errors++; $display("FAIL full_regrant_data: got %h want %h", bus.pe_i_data, slice_val(3)); end
    tick();
    bus.pe_ack = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL full_regrant_ready: got %b want 1000", bus.req_ready); end
    tick();
    bus.pe_ack    = 1'b0;
    bus.req_valid = 4'b0000;
    // Back-to-back results drain tags 0 then 1, leaving {2,3}
    bus.pe_o_valid = 1'b1;
    tick();
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL full_drain0: rsp_id got %0d want 0", bus.rsp_id); end
    tick();
    bus.pe_o_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1) begin errors++; $display("FAIL full_drain1: got valid=%b id=%0d want valid=1 id=1", bus.rsp_valid, bus.rsp_id); end
  endtask

  // Ack and result in the same cycle with two tags outstanding
  task automatic test_push_pop_same();
    bit ok;
    bus.req_valid = 4'b0010;
    wait_grant(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pp_grant_timeout: pe_i_valid got 0 want 1"); end
    checks++; if (bus.pe_i_data !== slice_val(1)) begin errors++; $display("FAIL pp_pe_i_data: got %h want %h", bus.pe_i_data, slice_val(1)); end
    tick();
    bus.pe_ack     = 1'b1;
    bus.pe_o_valid = 1'b1;
    bus.pe_o_data  = 32'h4000;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL pp_req_ready: got %b want 0010", bus.req_ready); end
    tick();
    bus.pe_ack     = 1'b0;
    bus.pe_o_valid = 1'b0;
    bus.req_valid  = 4'b0000;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin errors++; $display("FAIL pp_rsp_oldest: got valid=%b id=%0d want valid=1 id=2", bus.rsp_valid, bus.rsp_id); end
    bus.pe_o_valid = 1'b1;
    tick();
    checks++; if (bus.rsp_id !== 2'd3) begin errors++; $display("FAIL pp_rsp_next: rsp_id got %0d want 3", bus.rsp_id); end
    tick();
    bus.pe_o_valid = 1'b0;
    checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL pp_rsp_pushed: rsp_id got %0d want 1", bus.rsp_id); end
    checks++; if (bus.err_orphan !== 1'b0) begin errors++; $display("FAIL pp_no_orphan: err_orphan got %b want 0", bus.err_orphan); end
  endtask

  task automatic test_orphan();
    bus.pe_o_valid = 1'b1;
    bus.pe_o_data  = 32'h5555;
    tick();
    bus.pe_o_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL orphan_rsp_valid: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL orphan_rsp_id: got %0d want 0", bus.rsp_id); end
    checks++; if (bus.rsp_data !== 32'h5555) begin errors++; $display("FAIL orphan_rsp_data: got %h want 00005555", bus.rsp_data); end
    checks++; if (bus.err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got %b want 1", bus.err_orphan); end
    tick();
    tick();
    checks++; if (bus.err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", bus.err_orphan); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL orphan_pulse: rsp_valid got %b want 0", bus.rsp_valid); end
  endtask

  // Reset while granted with three tags outstanding
  task automatic test_reset_mid_op();
    int order[3] = '{2, 3, 0};
    bit ok;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_fill_timeout[%0d]: pe_i_valid got 0 want 1", i); end
      tick();
      bus.pe_ack = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'(1 << order[i])) begin errors++; $display("FAIL rst_fill_ready[%0d]: got %b want %b", i, bus.req_ready, 4'(1 << order[i])); end
      tick();
      bus.pe_ack = 1'b0;
    end
    wait_grant(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_grant_timeout: pe_i_valid got 0 want 1"); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus.pe_i_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_pe_i_valid: got %b want 0", bus.pe_i_valid); end
    checks++; if (bus.err_orphan !== 1'b0) begin errors++; $display("FAIL rst_mid_err_orphan: got %b want 0", bus.err_orphan); end
    rst_n          = 1'b1;
    bus.req_valid  = 4'b0000;
    bus.pe_o_valid = 1'b1;
    bus.pe_o_data  = 32'h6000;
    tick();
    bus.pe_o_valid = 1'b0;
    checks++; if (bus.err_orphan !== 1'b1 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rst_fifo_empty: got orphan=%b id=%0d want orphan=1 id=0", bus.err_orphan, bus.rsp_id); end
    bus.req_valid = 4'b1111;
    wait_grant(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_regrant_timeout: pe_i_valid got 0 want 1"); end
    checks++; if (bus.pe_i_data !== slice_val(0)) begin errors++; $display("FAIL rst_regrant_data: got %h want %h", bus.pe_i_data, slice_val(0)); end
    tick();
    bus.pe_ack = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_regrant_ready: got %b want 0001", bus.req_ready); end
    tick();
    bus.pe_ack    = 1'b0;
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_requester();
    test_fifo_full();
    test_push_pop_same();
    test_orphan();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
